// File: rtl/fb_mem_arbiter.sv
// Round-robin arbiter sharing one framebuffer memory port between NUM_REQ drawing engines,
// with an in-order read tag FIFO for routing return data. Optional macro: ARB_BURST_LOCK_EN.
module fb_mem_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int DW        = 32,
  parameter int AW        = 16,
  parameter int RD_DEPTH  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ*DW-1:0]   req_data,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*DW/8-1:0] req_wben,
  input  logic [NUM_REQ-1:0]      req_op,
  input  logic [NUM_REQ-1:0]      req_rts,
  output logic [NUM_REQ-1:0]      req_rtr,
  output logic [DW-1:0]           mem_data,
  output logic [AW-1:0]           mem_addr,
  output logic [DW/8-1:0]         mem_wben,
  output logic                    mem_op,
  output logic                    mem_rts,
  input  logic                    mem_rtr,
  input  logic [DW-1:0]           mem_rd_data,
  input  logic                    mem_rd_valid,
  output logic [DW-1:0]           arb_out_bcast_data,
  output logic [NUM_REQ-1:0]      arb_out_xfc,
  output logic                    busy,
  output logic                    rd_underflow
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int WB = DW / 8;

  if (NUM_REQ < 2 || NUM_REQ > 8 || RD_DEPTH < 2 || (RD_DEPTH & (RD_DEPTH - 1)) != 0 || BURST_MAX < 1)
  begin : g_param_check
    $error("fb_mem_arbiter: unsupported parameter combination");
  end

  // Handshake: a transfer happens on a cycle where rts && rtr are both high; rts must not
  // depend on rtr, and the sender holds its fields stable until that cycle.
  logic [IW-1:0] lst;
  logic [IW-1:0] win;
  logic          win_vld;
  logic          lock;
  logic          load_en;
  logic          stall;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] tag_mem [RD_DEPTH];

`ifdef ARB_BURST_LOCK_EN
  localparam int BW = $clog2(BURST_MAX + 1);
  logic [BW-1:0] burst_cnt;

  // While the last winner keeps requesting and has burst budget left, search starts at it.
  assign lock = (burst_cnt != '0) && (burst_cnt < BW'(BURST_MAX)) && req_rts[lst];

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (accept) begin
      burst_cnt <= (win == lst && burst_cnt != BW'(BURST_MAX)) ? burst_cnt + BW'(1) : BW'(1);
    end
  end
`else
  assign lock = 1'b0;
`endif

  always_comb begin
    int start;
    int idx;
    start   = lock ? int'(lst) : int'(lst) + 1;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (start + k) % NUM_REQ;
      if (!win_vld && req_rts[IW'(idx)]) begin
        win_vld = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  assign load_en = !mem_rts || mem_rtr;
  assign full    = (count == (PW+1)'(RD_DEPTH));
  // A read winner facing a full tag FIFO blocks everyone; we never skip past it.
  assign stall   = win_vld && !req_op[win] && full;
  assign accept  = win_vld && load_en && !stall;
  assign push    = accept && !req_op[win];
  assign pop     = mem_rd_valid && (count != '0);
  assign busy    = mem_rts || (count != '0);

  always_comb begin
    req_rtr = '0;
    if (accept) req_rtr[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rts  <= 1'b0;
      mem_data <= '0;
      mem_addr <= '0;
      mem_wben <= '0;
      mem_op   <= 1'b0;
      lst      <= IW'(NUM_REQ - 1);
    end else if (load_en) begin
      mem_rts <= accept;
      if (accept) begin
        mem_data <= req_data[int'(win)*DW +: DW];
        mem_addr <= req_addr[int'(win)*AW +: AW];
        mem_wben <= req_wben[int'(win)*WB +: WB];
        mem_op   <= req_op[win];
        lst      <= win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_out_bcast_data <= '0;
      arb_out_xfc        <= '0;
      rd_underflow       <= 1'b0;
    end else begin
      arb_out_xfc <= '0;
      if (pop) begin
        arb_out_bcast_data <= mem_rd_data;
        arb_out_xfc        <= NUM_REQ'(1) << tag_mem[rd_ptr];
      end
      if (mem_rd_valid && count == '0) rd_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: per-cycle vector tables plus hand sequences for reset,
// read return and underflow; memory-side transactions go through an expected queue.
module tb_fb_mem_arbiter;
  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int WB = DW / 8;
  localparam int SW = 1 + AW + DW + WB;
`ifdef ARB_BURST_LOCK_EN
  localparam int RR_N = 24;
`else
  localparam int RR_N = 6;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*WB-1:0] req_wben = '0;
  logic [NR-1:0]    req_op   = '0;
  logic [NR-1:0]    req_rts  = '0;
  logic [NR-1:0]    req_rtr;
  logic [DW-1:0]    mem_data;
  logic [AW-1:0]    mem_addr;
  logic [WB-1:0]    mem_wben;
  logic             mem_op;
  logic             mem_rts;
  logic             mem_rtr = 1'b0;
  logic [DW-1:0]    mem_rd_data = '0;
  logic             mem_rd_valid = 1'b0;
  logic [DW-1:0]    arb_out_bcast_data;
  logic [NR-1:0]    arb_out_xfc;
  logic             busy;
  logic             rd_underflow;

  always #5 clk = ~clk;

  fb_mem_arbiter #(.NUM_REQ(NR), .DW(DW), .AW(AW), .RD_DEPTH(4), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_addr(req_addr), .req_wben(req_wben),
    .req_op(req_op), .req_rts(req_rts), .req_rtr(req_rtr),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_wben(mem_wben), .mem_op(mem_op),
    .mem_rts(mem_rts), .mem_rtr(mem_rtr),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .arb_out_bcast_data(arb_out_bcast_data), .arb_out_xfc(arb_out_xfc),
    .busy(busy), .rd_underflow(rd_underflow)
  );

  typedef struct {
    logic [2:0]  rts;
    logic [2:0]  op;
    logic        mrtr;
    logic [15:0] addr;
    logic [31:0] data;
    logic        rdv;
    logic [31:0] rdd;
    logic [2:0]  exp_rtr;
    logic        exp_mrts;
    logic [2:0]  exp_xfc;
    logic [31:0] exp_bcast;
  } vec_t;

  vec_t          vq[$];
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] mon_e;
  int            checks = 0;
  int            passed = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [2:0] rts, logic [2:0] op, logic mrtr, logic [15:0] addr,
                              logic [31:0] data, logic rdv, logic [31:0] rdd, logic [2:0] exp_rtr,
                              logic exp_mrts, logic [2:0] exp_xfc, logic [31:0] exp_bcast);
    vec_t v;
    v.rts = rts; v.op = op; v.mrtr = mrtr; v.addr = addr; v.data = data;
    v.rdv = rdv; v.rdd = rdd; v.exp_rtr = exp_rtr; v.exp_mrts = exp_mrts;
    v.exp_xfc = exp_xfc; v.exp_bcast = exp_bcast;
    return v;
  endfunction

  // Each engine gets distinct fields derived from the vector's base values.
  function automatic logic [AW-1:0] e_addr(logic [15:0] a, int e);
    return a + {e[3:0], 12'h000};
  endfunction
  function automatic logic [DW-1:0] e_data(logic [31:0] d, int e);
    return {d[31:8], d[7:0] ^ e[7:0]};
  endfunction
  function automatic logic [WB-1:0] e_wben(int e);
    return 4'hF >> e;
  endfunction

  function automatic logic [2:0] rr_exp(int i);
`ifdef ARB_BURST_LOCK_EN
    return 3'b001 << (i / 8);
`else
    return 3'b001 << (i % 3);
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_rts = '0;
    mem_rd_valid = 1'b0;
    mem_rtr = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic run(string tag);
    foreach (vq[i]) begin
      for (int e = 0; e < NR; e++) begin
        req_rts[e] = vq[i].rts[e];
        req_op[e]  = vq[i].op[e];
        req_addr[e*AW +: AW] = e_addr(vq[i].addr, e);
        req_data[e*DW +: DW] = e_data(vq[i].data, e);
        req_wben[e*WB +: WB] = e_wben(e);
      end
      mem_rtr      = vq[i].mrtr;
      mem_rd_valid = vq[i].rdv;
      mem_rd_data  = vq[i].rdd;
      @(negedge clk);
      chk($sformatf("%s[%0d] req_rtr", tag, i), 64'(req_rtr), 64'(vq[i].exp_rtr));
      chk($sformatf("%s[%0d] mem_rts", tag, i), 64'(mem_rts), 64'(vq[i].exp_mrts));
      chk($sformatf("%s[%0d] xfc", tag, i), 64'(arb_out_xfc), 64'(vq[i].exp_xfc));
      if (vq[i].exp_xfc != 3'b000)
        chk($sformatf("%s[%0d] bcast", tag, i), 64'(arb_out_bcast_data), 64'(vq[i].exp_bcast));
      for (int e = 0; e < NR; e++)
        if (vq[i].exp_rtr[e])
          exp_q.push_back({vq[i].op[e], e_addr(vq[i].addr, e), e_data(vq[i].data, e), e_wben(e)});
      tick();
    end
    vq.delete();
    req_rts = '0;
    mem_rd_valid = 1'b0;
    mem_rtr = 1'b1;
    @(negedge clk);
    chk($sformatf("%s drain", tag), 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  // Memory-side scoreboard: a transaction completes on a cycle with mem_rts && mem_rtr.
  always @(negedge clk) begin
    if (!rst && mem_rts && mem_rtr) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL mem_extra: got txn addr 0x%0h, expected none", mem_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mem_txn", 64'({mem_op, mem_addr, mem_data, mem_wben}), 64'(mon_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mem_rts", 64'(mem_rts), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst xfc", 64'(arb_out_xfc), 64'd0);
    chk("rst bcast", 64'(arb_out_bcast_data), 64'd0);
    chk("rst underflow", 64'(rd_underflow), 64'd0);
    chk("rst req_rtr", 64'(req_rtr), 64'd0);
    tick();

    // Engine 0 alone: four back-to-back writes.
    do_reset();
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(3'b001, 3'b001, 1'b1, 16'(i), 32'h000F_000F, 1'b0, '0, 3'b001, i > 0, 3'b000, '0));
    vq.push_back(mk(3'b000, 3'b000, 1'b1, '0, '0, 1'b0, '0, 3'b000, 1'b1, 3'b000, '0));
    vq.push_back(mk(3'b000, 3'b000, 1'b1, '0, '0, 1'b0, '0, 3'b000, 1'b0, 3'b000, '0));
    run("single");
    @(negedge clk);
    chk("single busy_after", 64'(busy), 64'd0);
    tick();

    // All three engines writing continuously.
    do_reset();
    for (int i = 0; i < RR_N; i++)
      vq.push_back(mk(3'b111, 3'b111, 1'b1, 16'h0200 + 16'(i), 32'hB000_0000 + 32'(i << 8),
                      1'b0, '0, rr_exp(i), i > 0, 3'b000, '0));
    vq.push_back(mk(3'b000, 3'b000, 1'b1, '0, '0, 1'b0, '0, 3'b000, 1'b1, 3'b000, '0));
    vq.push_back(mk(3'b000, 3'b000, 1'b1, '0, '0, 1'b0, '0, 3'b000, 1'b0, 3'b000, '0));
    run("rr");

    // Memory back-pressure for five cycles with a write held in the output register.
    do_reset();
    vq.push_back(mk(3'b001, 3'b001, 1'b0, 16'h0100, 32'hC000_0100, 1'b0, '0, 3'b001, 1'b0, 3'b000, '0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(3'b010, 3'b010, 1'b0, 16'h0100, 32'hC000_0200, 1'b0, '0, 3'b000, 1'b1, 3'b000, '0));
    vq.push_back(mk(3'b010, 3'b010, 1'b1, 16'h0100, 32'hC000_0200, 1'b0, '0, 3'b010, 1'b1, 3'b000, '0));
    vq.push_back(mk(3'b000, 3'b000, 1'b1, '0, '0, 1'b0, '0, 3'b000, 1'b1, 3'b000, '0));
    vq.push_back(mk(3'b000, 3'b000, 1'b1, '0, '0, 1'b0, '0, 3'b000, 1'b0, 3'b000, '0));
    run("hold");

    // Engine 1 reads until the tag FIFO fills, then one return frees a slot.
    do_reset();
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(3'b010, 3'b000, 1'b1, 16'h0300 + 16'(i), 32'hD000_0000, 1'b0, '0, 3'b010, i > 0, 3'b000, '0));
    vq.push_back(mk(3'b010, 3'b000, 1'b1, 16'h0304, 32'hD000_0000, 1'b0, '0, 3'b000, 1'b1, 3'b000, '0));
    vq.push_back(mk(3'b010, 3'b000, 1'b1, 16'h0304, 32'hD000_0000, 1'b1, 32'hDEAD_BEEF, 3'b000, 1'b0, 3'b000, '0));
    vq.push_back(mk(3'b010, 3'b000, 1'b1, 16'h0304, 32'hD000_0000, 1'b0, '0, 3'b010, 1'b0, 3'b010, 32'hDEAD_BEEF));
    vq.push_back(mk(3'b000, 3'b000, 1'b1, '0, '0, 1'b0, '0, 3'b000, 1'b1, 3'b000, '0));
    vq.push_back(mk(3'b000, 3'b000, 1'b1, '0, '0, 1'b0, '0, 3'b000, 1'b0, 3'b000, '0));
    run("reads");

    // Four reads outstanding; return one, then reset with three still pending.
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'h1234_5678;
    tick();
    mem_rd_valid = 1'b0;
    @(negedge clk);
    chk("ret xfc", 64'(arb_out_xfc), 64'h2);
    chk("ret bcast", 64'(arb_out_bcast_data), 64'h1234_5678);
    chk("ret busy", 64'(busy), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst xfc", 64'(arb_out_xfc), 64'd0);
    chk("midrst mem_rts", 64'(mem_rts), 64'd0);
    tick();

    vq.push_back(mk(3'b111, 3'b111, 1'b1, 16'h0400, 32'hE000_0000, 1'b0, '0, 3'b001, 1'b0, 3'b000, '0));
    vq.push_back(mk(3'b000, 3'b000, 1'b1, '0, '0, 1'b0, '0, 3'b000, 1'b1, 3'b000, '0));
    vq.push_back(mk(3'b000, 3'b000, 1'b1, '0, '0, 1'b0, '0, 3'b000, 1'b0, 3'b000, '0));
    run("postrst");

    // Return strobe with no outstanding read.
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'h5555_5555;
    tick();
    mem_rd_valid = 1'b0;
    @(negedge clk);
    chk("uflow flag", 64'(rd_underflow), 64'd1);
    chk("uflow xfc", 64'(arb_out_xfc), 64'd0);
    chk("uflow bcast", 64'(arb_out_bcast_data), 64'd0);
    tick();
    @(negedge clk);
    chk("uflow sticky", 64'(rd_underflow), 64'd1);
    chk("uflow busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("uflow cleared", 64'(rd_underflow), 64'd0);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
